instruction_fetch: RTL and testbench

Fetch stage of the single-issue MIPS datapath; the requesting end of the instruction-memory read port. It owns the program counter and drives the word-aligned byte address to instruction memory. It captures the returned 32-bit word into an IF/ID register and hands it to decode over a valid/ready handshake. Branch/jump redirects from later stages flush the in-flight word and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_fetch_if_id_reg.sv | 30 +++
 rtl/instruction_fetch.sv | 81 ++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP    = 32'd4;
    localparam logic [ADDR_W-1:0]  ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: valid, instruction and its PC.
import fetch_pkg::*;

module if_id_reg (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] next_instr,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= next_instr;
            pc    <= next_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem request, IF/ID handshake, redirect flush.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
import fetch_pkg::*;

module instruction_fetch #(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               fetch_fault
);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic              load, flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        load    = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            // Misaligned target: trap and keep the old pc frozen
            if (redirect_target[1:0] != 2'b00) begin
                state_d = FAULT;
            end else begin
                state_d = RUN;
                pc_d    = redirect_target;
            end
`else
            pc_d = redirect_target & ALIGN_MASK;
`endif
        end else if (state == RUN && (!if_valid || if_ready)) begin
            load = 1'b1;
            pc_d = pc + PC_STEP;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (load),
        .next_instr (imem_instr),
        .next_pc    (pc),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    assign imem_addr   = pc;
    assign if_pc_plus4 = if_pc + PC_STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized + directed bench for instruction_fetch against a
// transaction-level fetch model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_fault;

    logic [31:0] mem [1024];

    int vectors = 0;
    int errors  = 0;

    // Reference state: what decode should currently see
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_fault;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[11:2]];

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_fault     (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_update(input logic r, input logic rv,
                                input logic [31:0] rt, input logic rdy);
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
            m_ipc = 32'h0; m_fault = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rt % 4 != 0) m_fault = 1'b1;
            else begin m_pc = rt; m_fault = 1'b0; end
`else
            m_pc = rt - (rt % 4);
`endif
        end else if (!m_fault && (!m_valid || rdy)) begin
            m_instr = mem[(m_pc % 4096) / 4];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic compare_model();
        check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        check("imem_addr", imem_addr, m_pc);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        if (m_valid) begin
            check("if_instr", if_instr, m_instr);
            check("if_pc", if_pc, m_ipc);
            check("if_pc_plus4", if_pc_plus4, m_ipc + 32'd4);
        end
    endtask

    task automatic step(input logic r, input logic rv,
                        input logic [31:0] rt, input logic rdy);
        rst = r; redirect_valid = rv; redirect_target = rt; if_ready = rdy;
        @(posedge clk);
        model_update(r, rv, rt, rdy);
        #1;
        compare_model();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h8C01_0000;
        mem[1] = 32'h8C02_0004;
        mem[2] = 32'h8C03_0008;
        mem[3] = 32'h2004_0064;
        mem[9] = 32'hAC06_0000;

        // Reset state
        step(1, 0, 0, 1);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // Sequential fetch with a 3-cycle stall on the second word
        step(0, 0, 0, 1);
        check("seq0", if_instr, 32'h8C01_0000);
        step(0, 0, 0, 1);
        check("seq1", if_instr, 32'h8C02_0004);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("stall_instr", if_instr, 32'h8C02_0004);
            check("stall_pc", if_pc, 32'h4);
            check("stall_addr", imem_addr, 32'h8);
        end
        step(0, 0, 0, 1);
        check("seq2", if_instr, 32'h8C03_0008);
        step(0, 0, 0, 1);
        check("seq3", if_instr, 32'h2004_0064);
        check("seq3_pc", if_pc, 32'hC);

        // Redirect during a stall
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 32'h24, 0);
        check("redir_flush", {31'b0, if_valid}, 32'd0);
        step(0, 0, 0, 1);
        check("redir_pc", if_pc, 32'h24);
        check("redir_instr", if_instr, 32'hAC06_0000);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        check("wrap_pc2", if_pc, 32'h0);
        check("wrap_plus4", if_pc_plus4, 32'h4);

        // Misaligned redirect
        step(0, 1, 32'h6, 1);
        step(0, 0, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_fault", {31'b0, fetch_fault}, 32'd1);
        check("trap_valid", {31'b0, if_valid}, 32'd0);
        step(0, 0, 0, 1);
        check("trap_hold", {31'b0, if_valid}, 32'd0);
        step(0, 1, 32'h10, 1);
        check("trap_clear", {31'b0, fetch_fault}, 32'd0);
        step(0, 0, 0, 1);
        check("trap_resume", if_pc, 32'h10);
`else
        check("misalign_pc", if_pc, 32'h4);
        check("misalign_fault", {31'b0, fetch_fault}, 32'd0);
`endif

        // Reset mid-stream
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        check("mid_rst_valid", {31'b0, if_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_fault", {31'b0, fetch_fault}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r, rv, rdy;
            logic [31:0] rt;
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rt  = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFF0 | (rt % 16);
            step(r, rv, rt, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
